// File: rtl/wb_ext_arbiter.sv
// wb_ext_arbiter: round-robin arbiter that shares one Wishbone slave port
// among MASTERS tile wb_ext requesters. Ownership lasts for the whole
// m_cyc_i window of the granted master (bursts included), with no preemption.
// Optional slave-response watchdog: define WB_EXT_ARB_TIMEOUT_EN to enable it.
module wb_ext_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MASTERS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MASTERS-1:0][AW-1:0]   m_adr_i,
  input  logic [MASTERS-1:0][DW-1:0]   m_dat_i,
  input  logic [MASTERS-1:0]           m_cyc_i,
  input  logic [MASTERS-1:0]           m_stb_i,
  input  logic [MASTERS-1:0]           m_we_i,
  input  logic [MASTERS-1:0][3:0]      m_sel_i,
  input  logic [MASTERS-1:0][2:0]      m_cti_i,
  input  logic [MASTERS-1:0][1:0]      m_bte_i,
  output logic [MASTERS-1:0]           m_ack_o,
  output logic [MASTERS-1:0]           m_rty_o,
  output logic [MASTERS-1:0]           m_err_o,
  output logic [MASTERS-1:0][DW-1:0]   m_dat_o,
  output logic [AW-1:0]                s_adr_o,
  output logic [DW-1:0]                s_dat_o,
  output logic [3:0]                   s_sel_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [2:0]                   s_cti_o,
  output logic [1:0]                   s_bte_o,
  input  logic                         s_ack_i,
  input  logic                         s_rty_i,
  input  logic                         s_err_i,
  input  logic [DW-1:0]                s_dat_i,
  output logic [MASTERS-1:0]           grant_o
);

  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // Reject illegal configurations at elaboration time.
  if (MASTERS < 2 || MASTERS > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("wb_ext_arbiter: MASTERS must be 2..16 and TIMEOUT 2..65535");
  end

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic          owned_s;
  logic          active_s;
  logic          found_s;
  logic [GW-1:0] pick_s;
  logic          to_hit_s;

  // First requester at or after ptr, wrapping modulo MASTERS.
  function automatic logic [GW:0] rr_pick(input logic [MASTERS-1:0] req,
                                          input logic [GW-1:0]      ptr);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int i = 0; i < MASTERS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= MASTERS) begin
        idx = idx - MASTERS;
      end
      if (!res[GW] && req[idx]) begin
        res = {1'b1, idx[GW-1:0]};
      end
    end
    return res;
  endfunction

  assign owned_s  = (state_q == ST_OWNED);
  // A transfer is live only while the owner keeps cyc high; the release
  // cycle (owner already dropped cyc) must not see slave terminations.
  assign active_s = owned_s & m_cyc_i[g_q];
  assign {found_s, pick_s} = rr_pick(m_cyc_i, ptr_q);

`ifdef WB_EXT_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        stall_s;

  assign stall_s  = active_s & m_stb_i[g_q] & ~(s_ack_i | s_rty_i | s_err_i);
  assign to_hit_s = stall_s & (wd_q == 16'(TIMEOUT - 1));

  // Watchdog next value: count stalled strobe cycles, restart on any response.
  always_comb begin
    wd_d = 16'd0;
    if (to_hit_s) begin
      wd_d = 16'd0;
    end else if (stall_s) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = 16'd0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Arbitration FSM next-state: grant in IDLE, hold while owner keeps cyc.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_OWNED;
          g_d     = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (!m_cyc_i[g_q]) begin
          state_d = ST_IDLE;
          ptr_d   = (g_q == GW'(MASTERS - 1)) ? {GW{1'b0}} : g_q + GW'(1);
        end else begin
          state_d = ST_OWNED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, grant index and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= {GW{1'b0}};
      ptr_q   <= {GW{1'b0}};
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end

  // Datapath muxing: owner drives the slave port, slave answers only the owner.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = 4'b0000;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    m_ack_o = '0;
    m_rty_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    grant_o = '0;
    if (owned_s) begin
      s_adr_o      = m_adr_i[g_q];
      s_dat_o      = m_dat_i[g_q];
      s_sel_o      = m_sel_i[g_q];
      s_cyc_o      = m_cyc_i[g_q];
      s_stb_o      = m_stb_i[g_q] & ~to_hit_s;
      s_we_o       = m_we_i[g_q];
      s_cti_o      = m_cti_i[g_q];
      s_bte_o      = m_bte_i[g_q];
      grant_o[g_q] = 1'b1;
      if (active_s) begin
        m_ack_o[g_q] = s_ack_i;
        m_rty_o[g_q] = s_rty_i;
        m_err_o[g_q] = s_err_i | to_hit_s;
        m_dat_o[g_q] = s_dat_i;
      end else begin
        m_ack_o = '0;
      end
    end else begin
      grant_o = '0;
    end
  end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed self-checking bench for wb_ext_arbiter (4 masters, TIMEOUT=8).
module tb_wb_ext_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0][31:0] m_adr, m_dat_w;
  logic [3:0]       m_cyc, m_stb, m_we;
  logic [3:0][3:0]  m_sel;
  logic [3:0][2:0]  m_cti;
  logic [3:0][1:0]  m_bte;
  logic [3:0]       m_ack, m_rty, m_err;
  logic [3:0][31:0] m_dat_r;
  logic [31:0]      s_adr, s_dat_w, s_dat_r;
  logic [3:0]       s_sel;
  logic             s_cyc, s_stb, s_we, s_ack, s_rty, s_err;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic [3:0]       grant;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  wb_ext_arbiter #(.AW(32), .DW(32), .MASTERS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_we_i(m_we), .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack), .m_rty_o(m_rty), .m_err_o(m_err), .m_dat_o(m_dat_r),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_cyc_o(s_cyc),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_ack_i(s_ack), .s_rty_i(s_rty), .s_err_i(s_err), .s_dat_i(s_dat_r),
    .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  task automatic clear_inputs();
    m_adr = '0; m_dat_w = '0; m_cyc = 4'b0000; m_stb = 4'b0000; m_we = 4'b0000;
    m_sel = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_rty = 1'b0; s_err = 1'b0; s_dat_r = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    m_cyc = 4'b0001; m_stb = 4'b0001; s_ack = 1'b1;
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else pass_cnt++;
    chk_cnt++;
    if ({s_cyc, s_stb, m_ack} !== 6'b0) $display("FAIL reset_outs: got %b want 000000", {s_cyc, s_stb, m_ack}); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    #1;
    chk_cnt++;
    if (grant !== 4'b0000) $display("FAIL reset_hold: got %b want 0000", grant); else pass_cnt++;
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2] = 32'h100;
    #1;
    chk_cnt++;
    if (grant !== 4'b0000) $display("FAIL single_latency: got %b want 0000", grant); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else pass_cnt++;
    chk_cnt++;
    if (s_adr !== 32'h100 || s_cyc !== 1'b1 || s_stb !== 1'b1)
      $display("FAIL single_slave_port: got adr=%h cyc=%b stb=%b want 100 1 1", s_adr, s_cyc, s_stb);
    else pass_cnt++;
    @(negedge clk); @(negedge clk);
    #1;
    chk_cnt++;
    if (m_ack !== 4'b0000) $display("FAIL single_no_early_ack: got %b want 0000", m_ack); else pass_cnt++;
    @(negedge clk);
    s_ack = 1'b1; s_dat_r = 32'hCAFE_0002;
    #1;
    chk_cnt++;
    if (m_ack !== 4'b0100) $display("FAIL single_ack: got %b want 0100", m_ack); else pass_cnt++;
    chk_cnt++;
    if (m_dat_r[2] !== 32'hCAFE_0002 || m_dat_r[0] !== 32'h0)
      $display("FAIL single_rdata: got d2=%h d0=%h want cafe0002 0", m_dat_r[2], m_dat_r[0]);
    else pass_cnt++;
    @(negedge clk);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    #1;
    chk_cnt++;
    if (grant !== 4'b0100 || s_cyc !== 1'b0 || m_ack !== 4'b0000)
      $display("FAIL single_release: got grant=%b cyc=%b ack=%b want 0100 0 0000", grant, s_cyc, m_ack);
    else pass_cnt++;
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk_cnt++;
    if (grant !== 4'b0000) $display("FAIL single_idle: got %b want 0000", grant); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int         order [3];
    order[0] = 0; order[1] = 1; order[2] = 3;
    do_reset();
    @(negedge clk);
    m_cyc = 4'b1011; m_stb = 4'b1011;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_g = 4'b0001 << order[k];
      #1;
      chk_cnt++;
      if (grant !== exp_g) $display("FAIL rr_grant%0d: got %b want %b", k, grant, exp_g); else pass_cnt++;
      s_ack = 1'b1;
      #1;
      chk_cnt++;
      if (m_ack !== exp_g) $display("FAIL rr_ack%0d: got %b want %b", k, m_ack, exp_g); else pass_cnt++;
      @(negedge clk);
      s_ack = 1'b0;
      m_cyc[order[k]] = 1'b0; m_stb[order[k]] = 1'b0;
      #1;
      chk_cnt++;
      if (grant !== exp_g || s_cyc !== 1'b0)
        $display("FAIL rr_release%0d: got grant=%b cyc=%b want %b 0", k, grant, s_cyc, exp_g);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++;
      if (grant !== 4'b0000) $display("FAIL rr_idle%0d: got %b want 0000", k, grant); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_burst();
    int acks1;
    acks1 = 0;
    do_reset();
    @(negedge clk);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010; m_bte[1] = 2'b00;
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      #1;
      if (m_ack == 4'b0010) acks1++;
      chk_cnt++;
      if (grant !== 4'b0010 || m_ack !== 4'b0010)
        $display("FAIL burst_beat%0d: got grant=%b ack=%b want 0010 0010", b, grant, m_ack);
      else pass_cnt++;
      @(negedge clk);
    end
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    chk_cnt++;
    if (acks1 !== 4) $display("FAIL burst_ack_count: got %0d want 4", acks1); else pass_cnt++;
    #1;
    chk_cnt++;
    if (grant !== 4'b0010) $display("FAIL burst_release: got %b want 0010", grant); else pass_cnt++;
    @(negedge clk); @(negedge clk); #1;
    chk_cnt++;
    if (grant !== 4'b0001) $display("FAIL burst_next_owner: got %b want 0001", grant); else pass_cnt++;
    m_cyc = 4'b0000; m_stb = 4'b0000;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(negedge clk); #1;
    chk_cnt++;
    if (grant !== 4'b0100) $display("FAIL rstmid_grant: got %b want 0100", grant); else pass_cnt++;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    s_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (s_cyc !== 1'b0 || grant !== 4'b0000 || m_ack !== 4'b0000)
      $display("FAIL rstmid_abort: got cyc=%b grant=%b ack=%b want 0 0000 0000", s_cyc, grant, m_ack);
    else pass_cnt++;
    @(negedge clk);
    s_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_cnt++;
    if (grant !== 4'b0001) $display("FAIL rstmid_restart: got %b want 0001", grant); else pass_cnt++;
    m_cyc = 4'b0000; m_stb = 4'b0000;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_timeout();
    int errs;
    errs = 0;
    do_reset();
    @(negedge clk);
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
`ifdef WB_EXT_ARB_TIMEOUT_EN
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk); #1;
      if (n == 8) begin
        chk_cnt++;
        if (m_err !== 4'b1000 || s_stb !== 1'b0)
          $display("FAIL timeout_hit: got err=%b stb=%b want 1000 0", m_err, s_stb);
        else pass_cnt++;
      end else begin
        if (m_err !== 4'b0000 || s_stb !== 1'b1) errs++;
      end
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL timeout_quiet: got %0d bad cycles want 0", errs); else pass_cnt++;
`else
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk); #1;
      if (m_err !== 4'b0000) errs++;
    end
    chk_cnt++;
    if (errs !== 0) $display("FAIL no_timeout_err: got %0d err cycles want 0", errs); else pass_cnt++;
    chk_cnt++;
    if (s_stb !== 1'b1 || grant !== 4'b1000)
      $display("FAIL no_timeout_hold: got stb=%b grant=%b want 1 1000", s_stb, grant);
    else pass_cnt++;
`endif
    m_cyc = 4'b0000; m_stb = 4'b0000;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
